ioctl_uploader: RTL and testbench
=================================

IOCTL_UPLOADER -- requirements
Module: ioctl_uploader

Interface
REQ-001 Parameter ADDR_W, default 13, memory address width in bits (8 KB cart/BIOS region).
REQ-002 Parameter READ_LAT, default 1, memory read latency in clk_sys cycles from the mem_rd cycle to valid mem_q; legal range 1..3.
REQ-003 clk_sys  in  1  system clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ioctl_upload  in  1  HPS upload session active (level).
REQ-006 ioctl_rd  in  1  single-cycle request for the byte at ioctl_addr.
REQ-007 ioctl_addr  in  25  byte address of the current request.
REQ-008 ioctl_din  out  8  byte returned to HPS.
REQ-009 ioctl_wait  out  1  high while a request is unresolved; HPS holds off.
REQ-010 region_size  in  ADDR_W+1  number of valid bytes, 0..2^ADDR_W.
REQ-011 mem_addr  out  ADDR_W  memory read address.
REQ-012 mem_rd  out  1  one-cycle memory read strobe.
REQ-013 mem_q  in  8  memory read data.
REQ-014 byte_count  out  ADDR_W+1  bytes served in the current session, saturating at 2^ADDR_W.
REQ-015 overrun  out  1  sticky: ioctl_rd seen while busy.
REQ-016 done  out  1  one-cycle pulse at end of session.

Function
REQ-017 States are IDLE, ISSUE, LATENCY, PRESENT; the FSM is in IDLE whenever ioctl_upload is low.
REQ-018 IDLE + ioctl_upload=1 + ioctl_rd=1: the FSM latches ioctl_addr[ADDR_W-1:0], sets ioctl_wait=1 on the next edge, and goes to ISSUE.
REQ-019 ISSUE: mem_rd=1 for exactly one cycle, mem_addr=latched address; the FSM then goes to LATENCY.
REQ-020 LATENCY: a counter spans READ_LAT cycles; on the cycle mem_q is valid, the FSM captures the byte into ioctl_din and goes to PRESENT.
REQ-021 PRESENT: ioctl_wait=0, byte_count increments by 1 (saturating), then the FSM returns to IDLE; ioctl_din holds until the next capture.
REQ-022 Latency rule: ioctl_wait rises 1 cycle after ioctl_rd; with READ_LAT=1 it falls exactly 4 cycles after ioctl_rd.
REQ-023 Out-of-range requests (full ioctl_addr >= region_size, including any set upper bits) are zero-filled.
REQ-024 A zero-filled request drives no mem_rd, captures 8'h00, keeps identical cycle timing, and still counts.
REQ-025 region_size=0: every byte reads 8'h00.
REQ-026 ioctl_rd outside IDLE is ignored and sets overrun=1; overrun clears only on reset or a rising edge of ioctl_upload.
REQ-027 ioctl_rd while ioctl_upload=0 is ignored with no flag set.
REQ-028 ioctl_upload falling in any state: the FSM aborts to IDLE next cycle, ioctl_wait=0, mem_rd=0, done pulses once, and an aborted byte is not counted.
REQ-029 A rising edge of ioctl_upload clears byte_count and overrun.
REQ-030 Simultaneous ioctl_upload rise and ioctl_rd: the request is accepted with the cleared count.

Reset
REQ-031 Reset is asynchronous, active-high; in reset the FSM is IDLE and ioctl_din=8'h00, ioctl_wait=0, mem_rd=0, mem_addr=0, byte_count=0, overrun=0, done=0.
REQ-032 Reset mid-request abandons the request and produces no done pulse; after reset release the block accepts a new request on the first cycle.

Structure
REQ-033 The state enum and the zero-fill byte constant (8'h00) live in the shared astrocade_pkg.
REQ-034 The block is a single module; the READ_LAT delay counter is inline and no sub-module is used.
REQ-035 All outputs are registered.

Verification
REQ-036 Memory preloaded with mem[0x0005]=0xA5, region_size=8192: upload=1, rd at addr 5 -> wait high cycles 1-3, mem_addr=5, ioctl_din=0xA5, byte_count=1.
REQ-037 region_size=4, rd at addr 4 and at addr 0x2000 -> ioctl_din=0x00 both times, no mem_rd, byte_count=2.
REQ-038 Second rd one cycle after the first -> overrun=1, first byte still returned correctly, byte_count=1.
REQ-039 Upload dropped during LATENCY -> wait=0 next cycle, single done pulse, byte_count unchanged.
REQ-040 READ_LAT=3, rd at addr 0x1FFF with mem=0x3C -> wait falls 6 cycles after rd, ioctl_din=0x3C.
REQ-041 Reset asserted during ISSUE -> all outputs at reset values immediately; rd after release is served normally.

Source files
------------

// File: rtl/astrocade_pkg.sv
// Shared Astrocade core definitions: upload FSM state encoding and fill constants.
package astrocade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LATENCY,
        ST_PRESENT
    } upl_state_e;

    localparam logic [7:0] ZERO_FILL_BYTE = 8'h00;

endpackage

// File: rtl/ioctl_uploader.sv
// Serves HPS ioctl upload reads from a cart/BIOS memory region, one byte per request,
// stalling the HPS with ioctl_wait until the byte is captured.
module ioctl_uploader
    import astrocade_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int READ_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    input  logic [ADDR_W:0]   region_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_q,
    output logic [ADDR_W:0]   byte_count,
    output logic              overrun,
    output logic              done
);

    localparam int CMP_W = (ADDR_W + 1 > 25) ? ADDR_W + 1 : 25;
    localparam logic [1:0]      LAT_INIT = 2'(READ_LAT - 1);
    localparam logic [ADDR_W:0] CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

    upl_state_e        state_q, state_d;
    logic              upl_q;
    logic              zf_q, zf_d;
    logic [1:0]        lat_q, lat_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovr_q, ovr_d;
    logic              done_q, done_d;
    logic              out_of_range;
    logic              upl_rise;

    // Upper address bits beyond the region are part of the compare, so they zero-fill too.
    assign out_of_range = (CMP_W'(ioctl_addr) >= CMP_W'(region_size));
    assign upl_rise     = ioctl_upload && !upl_q;

    always_comb begin
        state_d    = state_q;
        zf_d       = zf_q;
        lat_d      = lat_q;
        din_d      = din_q;
        wait_d     = wait_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        ovr_d      = ovr_q;
        done_d     = 1'b0;

        if (upl_rise) begin
            cnt_d = '0;
            ovr_d = 1'b0;
        end

        if (!ioctl_upload) begin
            state_d = ST_IDLE;
            wait_d  = 1'b0;
            done_d  = upl_q;
        end else begin
            if (ioctl_rd && (state_q != ST_IDLE)) begin
                ovr_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (ioctl_rd) begin
                        mem_addr_d = ioctl_addr[ADDR_W-1:0];
                        zf_d       = out_of_range;
                        mem_rd_d   = !out_of_range;
                        wait_d     = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    lat_d   = LAT_INIT;
                    state_d = ST_LATENCY;
                end
                ST_LATENCY: begin
                    if (lat_q == 2'd0) begin
                        din_d   = zf_q ? ZERO_FILL_BYTE : mem_q;
                        state_d = ST_PRESENT;
                    end else begin
                        lat_d = lat_q - 2'd1;
                    end
                end
                ST_PRESENT: begin
                    wait_d  = 1'b0;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            upl_q      <= 1'b0;
            zf_q       <= 1'b0;
            lat_q      <= '0;
            din_q      <= ZERO_FILL_BYTE;
            wait_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            ovr_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            upl_q      <= ioctl_upload;
            zf_q       <= zf_d;
            lat_q      <= lat_d;
            din_q      <= din_d;
            wait_q     <= wait_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            ovr_q      <= ovr_d;
            done_q     <= done_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign byte_count = cnt_q;
    assign overrun    = ovr_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ioctl_uploader.sv
// Bench for ioctl_uploader: two instances (READ_LAT 1 and 3) driven in lockstep from directed and random reads.
module tb_ioctl_uploader;

    localparam int AW = 13;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic          reset;
    logic          ioctl_upload;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [AW:0]   region_size;

    logic [7:0]    din_a, din_b, q_a, q_b;
    logic          wait_a, wait_b, rd_a, rd_b, ovr_a, ovr_b, done_a, done_b;
    logic [AW-1:0] maddr_a, maddr_b;
    logic [AW:0]   cnt_a, cnt_b;

    logic [7:0]    mem [0:8191];
    logic [7:0]    pipe_a;
    logic [7:0]    pipe_b [0:2];
    int            nrd_a = 0;
    int            nrd_b = 0;

    int            checks = 0;
    int            errors = 0;
    int            m_cnt;
    bit            m_ovr;

    ioctl_uploader #(.ADDR_W(AW), .READ_LAT(1)) u_lat1 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(din_a), .ioctl_wait(wait_a), .region_size(region_size),
        .mem_addr(maddr_a), .mem_rd(rd_a), .mem_q(q_a), .byte_count(cnt_a), .overrun(ovr_a),
        .done(done_a)
    );

    ioctl_uploader #(.ADDR_W(AW), .READ_LAT(3)) u_lat3 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(din_b), .ioctl_wait(wait_b), .region_size(region_size),
        .mem_addr(maddr_b), .mem_rd(rd_b), .mem_q(q_b), .byte_count(cnt_b), .overrun(ovr_b),
        .done(done_b)
    );

    // Memory models: data is valid READ_LAT cycles after the strobe cycle, junk otherwise.
    always @(posedge clk_sys) begin
        pipe_a    <= rd_a ? mem[maddr_a] : 8'hEE;
        pipe_b[0] <= rd_b ? mem[maddr_b] : 8'hEE;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (rd_a) nrd_a <= nrd_a + 1;
        if (rd_b) nrd_b <= nrd_b + 1;
    end
    assign q_a = pipe_a;
    assign q_b = pipe_b[2];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [24:0] a);
        if (26'(a) >= 26'(region_size)) return 8'h00;
        return mem[a[12:0]];
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_din_a"}, 32'(din_a), 0);    chk({tag, "_din_b"}, 32'(din_b), 0);
        chk({tag, "_wait_a"}, 32'(wait_a), 0);  chk({tag, "_wait_b"}, 32'(wait_b), 0);
        chk({tag, "_rd_a"}, 32'(rd_a), 0);      chk({tag, "_rd_b"}, 32'(rd_b), 0);
        chk({tag, "_maddr_a"}, 32'(maddr_a), 0); chk({tag, "_maddr_b"}, 32'(maddr_b), 0);
        chk({tag, "_cnt_a"}, 32'(cnt_a), 0);    chk({tag, "_cnt_b"}, 32'(cnt_b), 0);
        chk({tag, "_ovr_a"}, 32'(ovr_a), 0);    chk({tag, "_ovr_b"}, 32'(ovr_b), 0);
        chk({tag, "_done_a"}, 32'(done_a), 0);  chk({tag, "_done_b"}, 32'(done_b), 0);
    endtask

    // One request; with dup a second rd follows one cycle later and must be flagged as overrun.
    task automatic do_read(input string tag, input logic [24:0] a, input bit dup);
        int   n_a0, n_b0, fall_a, fall_b, k;
        logic [7:0] e;
        bit   inr;
        e      = exp_byte(a);
        inr    = (26'(a) < 26'(region_size));
        n_a0   = nrd_a;
        n_b0   = nrd_b;
        fall_a = -1;
        fall_b = -1;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        k = 1;
        chk({tag, "_wait_rise_a"}, 32'(wait_a), 1);
        chk({tag, "_wait_rise_b"}, 32'(wait_b), 1);
        if (dup) begin
            ioctl_addr = a ^ 25'h1;
            tick();
            k = 2;
        end
        ioctl_rd = 1'b0;
        while (k < 10) begin
            tick();
            k++;
            if (fall_a < 0 && !wait_a) fall_a = k;
            if (fall_b < 0 && !wait_b) fall_b = k;
        end
        m_ovr = m_ovr | dup;
        if (m_cnt < 8192) m_cnt++;
        chk({tag, "_fall_a"}, 32'(fall_a), 4);
        chk({tag, "_fall_b"}, 32'(fall_b), 6);
        chk({tag, "_din_a"}, 32'(din_a), 32'(e));
        chk({tag, "_din_b"}, 32'(din_b), 32'(e));
        chk({tag, "_nrd_a"}, 32'(nrd_a - n_a0), inr ? 1 : 0);
        chk({tag, "_nrd_b"}, 32'(nrd_b - n_b0), inr ? 1 : 0);
        if (inr) begin
            chk({tag, "_maddr_a"}, 32'(maddr_a), 32'(a[12:0]));
            chk({tag, "_maddr_b"}, 32'(maddr_b), 32'(a[12:0]));
        end
        chk({tag, "_cnt_a"}, 32'(cnt_a), 32'(m_cnt));
        chk({tag, "_cnt_b"}, 32'(cnt_b), 32'(m_cnt));
        chk({tag, "_ovr_a"}, 32'(ovr_a), 32'(m_ovr));
        chk({tag, "_ovr_b"}, 32'(ovr_b), 32'(m_ovr));
    endtask

    task automatic new_session(input string tag);
        ioctl_upload = 1'b0;
        tick();
        chk({tag, "_done_a"}, 32'(done_a), 1);
        chk({tag, "_done_b"}, 32'(done_b), 1);
        tick();
        chk({tag, "_done_end_a"}, 32'(done_a), 0);
        chk({tag, "_done_end_b"}, 32'(done_b), 0);
        ioctl_upload = 1'b1;
        tick();
        m_cnt = 0;
        m_ovr = 1'b0;
        chk({tag, "_clr_cnt_a"}, 32'(cnt_a), 0);
        chk({tag, "_clr_cnt_b"}, 32'(cnt_b), 0);
        chk({tag, "_clr_ovr_a"}, 32'(ovr_a), 0);
        chk({tag, "_clr_ovr_b"}, 32'(ovr_b), 0);
    endtask

    initial begin
        logic [24:0] ra;
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        region_size  = 14'd8192;
        m_cnt        = 0;
        m_ovr        = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[13'h0005] = 8'hA5;
        mem[13'h1FFF] = 8'h3C;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // rd while no upload session is ignored without a flag
        ioctl_addr = 25'h5;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        chk("noupl_wait_a", 32'(wait_a), 0);
        chk("noupl_wait_b", 32'(wait_b), 0);
        chk("noupl_ovr_a", 32'(ovr_a), 0);
        chk("noupl_nrd", 32'(nrd_a + nrd_b), 0);

        ioctl_upload = 1'b1;
        tick();
        do_read("basic5", 25'h5, 1'b0);
        do_read("top1fff", 25'h1FFF, 1'b0);

        new_session("s_zf");
        region_size = 14'd4;
        do_read("zf4", 25'h4, 1'b0);
        do_read("zf2000", 25'h2000, 1'b0);
        region_size = 14'd0;
        do_read("sz0_a0", 25'h0, 1'b0);
        do_read("sz0_a100", 25'h100, 1'b0);

        region_size = 14'd8192;
        new_session("s_ovr");
        do_read("ovr", 25'h5, 1'b1);
        new_session("s_ovrclr");

        // drop upload while both instances are waiting on memory
        do_read("pre_abort", 25'h1FFF, 1'b0);
        ioctl_addr = 25'h5;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        ioctl_upload = 1'b0;
        tick();
        chk("abort_wait_a", 32'(wait_a), 0);
        chk("abort_wait_b", 32'(wait_b), 0);
        chk("abort_done_a", 32'(done_a), 1);
        chk("abort_done_b", 32'(done_b), 1);
        tick();
        chk("abort_done_end_a", 32'(done_a), 0);
        chk("abort_done_end_b", 32'(done_b), 0);
        chk("abort_cnt_a", 32'(cnt_a), 32'(m_cnt));
        chk("abort_cnt_b", 32'(cnt_b), 32'(m_cnt));

        // upload rise together with rd: accepted against a cleared count
        ioctl_upload = 1'b1;
        m_cnt = 0;
        m_ovr = 1'b0;
        do_read("rise_rd", 25'h5, 1'b0);

        for (int n = 0; n < 16; n++) begin
            if (n % 8 == 0) region_size = 14'($urandom_range(0, 8192));
            ra = ($urandom_range(0, 3) == 0) ? 25'($urandom) : 25'($urandom_range(0, 8191));
            do_read("rand", ra, 1'b0);
        end

        // reset while the request is in ISSUE
        region_size = 14'd8192;
        ioctl_addr  = 25'h5;
        ioctl_rd    = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        reset    = 1'b1;
        #1;
        chk_reset_vals("rst_issue");
        tick();
        reset = 1'b0;
        m_cnt = 0;
        m_ovr = 1'b0;
        do_read("post_rst", 25'h1FFF, 1'b0);
        chk("post_rst_done_a", 32'(done_a), 0);
        chk("post_rst_done_b", 32'(done_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
